// File: rtl/ls_fetch_sequencer_if.sv
// Core-facing and program-load bus of the fetch sequencer.
// master: the side that loads the program and supplies pc (core/testbench).
// slave:  the sequencer itself.
interface ls_fetch_sequencer_if #(
    parameter int AW = 5
);
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic [15:0]   pc_in;
    logic [15:0]   ins;
    logic          en_in;
    logic          en2;

    modport master (
        output load_we, load_addr, load_data, pc_in,
        input  ins, en_in, en2
    );

    modport slave (
        input  load_we, load_addr, load_data, pc_in,
        output ins, en_in, en2
    );
endinterface

// File: rtl/ls_fetch_sequencer.sv
// Instruction fetch/issue controller for the load/store core.
// Holds a loadable program memory, fetches the word at pc_in, registers it
// onto ins and strobes en2 once per instruction under run/step/halt control.
module ls_fetch_sequencer #(
    parameter int          AW          = 5,
    parameter int          EXEC_CYCLES = 2,
    parameter logic [15:0] HALT_WORD   = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step,
    ls_fetch_sequencer_if.slave  bus,
    output logic                 busy,
    output logic                 halted,
    output logic                 pc_err,
    output logic [15:0]          instr_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

    // Counter is loaded with EXEC_CYCLES-1 so that zero marks the last EXEC cycle.
    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t      state;
    logic [3:0]  exec_cnt;
    logic        step_flag;
    logic [15:0] mem [2**AW];
    logic [15:0] fetch_word;
    logic        pc_oob;
    logic        load_ok;

    assign fetch_word = mem[bus.pc_in[AW-1:0]];
    assign pc_oob     = |bus.pc_in[15:AW];
    // Writes are only accepted while the core is not executing, so a load can
    // never race a fetch.
    assign load_ok    = (state == S_IDLE) || (state == S_HALT);

    // Program memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.load_we && load_ok)
            mem[bus.load_addr] <= bus.load_data;
    end

    // Sequencer FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            exec_cnt    <= '0;
            step_flag   <= 1'b0;
            bus.ins     <= 16'h0000;
            bus.en_in   <= 1'b0;
            bus.en2     <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            pc_err      <= 1'b0;
            instr_count <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run || step) begin
                        state     <= S_FETCH;
                        // run dominates: a simultaneous step does not make this a single-step
                        step_flag <= step && !run;
                        bus.en_in <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (pc_oob || (fetch_word == HALT_WORD)) begin
                        if (pc_oob)
                            pc_err <= 1'b1;
                        state     <= S_HALT;
                        step_flag <= 1'b0;
                        halted    <= 1'b1;
                        bus.en_in <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        bus.ins <= fetch_word;
                        bus.en2 <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    bus.en2     <= 1'b0;
                    instr_count <= instr_count + 16'd1;
                    exec_cnt    <= EXEC_LAST;
                    state       <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_cnt != 4'd0) begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end else if (run && !step_flag) begin
                        state <= S_FETCH;
                    end else begin
                        step_flag <= 1'b0;
                        state     <= S_IDLE;
                        bus.en_in <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (!run && !step) begin
                        state  <= S_IDLE;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    bus.en_in <= 1'b0;
                    bus.en2   <= 1'b0;
                    busy      <= 1'b0;
                    halted    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ls_fetch_sequencer.sv
// Scoreboard bench for ls_fetch_sequencer: expected issued words are queued
// by the stimulus, a monitor pops and compares on every en2 pulse.
module tb_ls_fetch_sequencer;
    localparam logic [15:0] HALT = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        step;
    logic        busy;
    logic        halted;
    logic        pc_err;
    logic [15:0] instr_count;

    ls_fetch_sequencer_if #(.AW(5)) bus ();

    ls_fetch_sequencer #(.AW(5), .EXEC_CYCLES(2), .HALT_WORD(16'hFFFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .bus         (bus),
        .busy        (busy),
        .halted      (halted),
        .pc_err      (pc_err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];
    int          en2_cyc [$];
    int          cyc = 0;
    int          pc_req_seq = 0;
    logic [15:0] pc_req_val = 16'h0;
    logic [15:0] model_mem [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core behaviour: next pc is pc+1, or a short forward jump when bit 15 is set.
    function automatic logic [15:0] next_pc(input logic [15:0] pc, input logic [15:0] w);
        return w[15] ? pc + 16'd2 + {14'd0, w[1:0]} : pc + 16'd1;
    endfunction

    // Core model: owns pc_in; applies explicit pc loads, otherwise advances on en2.
    initial begin
        int seen = 0;
        bus.pc_in = 16'h0;
        forever begin
            @(negedge clk);
            if (pc_req_seq != seen) begin
                bus.pc_in = pc_req_val;
                seen = pc_req_seq;
            end else if (bus.en2) begin
                bus.pc_in = next_pc(bus.pc_in, bus.ins);
            end
        end
    end

    // Monitor: every en2 must match the head of the scoreboard queue.
    initial begin
        logic        prev_en2 = 1'b0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst && bus.en2) begin
                chk("en2_back_to_back", {31'd0, prev_en2}, 32'd0);
                en2_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_en2: ins %0h with empty queue at %0t", bus.ins, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_ins", {16'd0, bus.ins}, {16'd0, e});
                end
            end
            prev_en2 = bus.en2;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        run = 1'b0;
        step = 1'b0;
        bus.load_we = 1'b0;
        exp_q.delete();
        ticks(2);
        rst = 1'b1;
        tick();
    endtask

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        bus.load_we = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        tick();
        bus.load_we = 1'b0;
    endtask

    task automatic set_pc(input logic [15:0] v);
        pc_req_val = v;
        pc_req_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic wait_en2(input string name);
        for (int i = 0; i < 50; i++) begin
            if (bus.en2) break;
            tick();
        end
        chk(name, {31'd0, bus.en2}, 32'd1);
    endtask

    task automatic wait_halted(input string name);
        for (int i = 0; i < 1000; i++) begin
            if (halted) break;
            tick();
        end
        chk(name, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        int          pc;
        int          n;
        logic        exp_err;
        logic [15:0] w;

        rst = 1'b0;
        run = 1'b0;
        step = 1'b0;
        bus.load_we = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        ticks(4);
        chk("rst_ins", {16'd0, bus.ins}, 32'h0);
        chk("rst_en_in", {31'd0, bus.en_in}, 32'd0);
        chk("rst_en2", {31'd0, bus.en2}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc_err", {31'd0, pc_err}, 32'd0);
        chk("rst_count", {16'd0, instr_count}, 32'd0);
        rst = 1'b1;
        tick();

        // Run through a three-word program ending in halt.
        load(5'd0, 16'h0401);
        load(5'd1, 16'h2401);
        load(5'd2, HALT);
        set_pc(16'd0);
        en2_cyc.delete();
        exp_q.push_back(16'h0401);
        exp_q.push_back(16'h2401);
        run = 1'b1;
        wait_halted("run_halted");
        chk("run_en_in", {31'd0, bus.en_in}, 32'd0);
        chk("run_count", {16'd0, instr_count}, 32'd2);
        chk("run_pulses", en2_cyc.size(), 32'd2);
        if (en2_cyc.size() == 2)
            chk("run_period", en2_cyc[1] - en2_cyc[0], 32'd4);
        run = 1'b0;
        ticks(2);
        chk("run_idle", {31'd0, halted}, 32'd0);

        // Single step, twice.
        do_reset();
        load(5'd0, 16'h0401);
        load(5'd1, 16'h1111);
        set_pc(16'd0);
        exp_q.push_back(16'h0401);
        pulse_step();
        ticks(6);
        chk("step1_busy", {31'd0, busy}, 32'd0);
        chk("step1_count", {16'd0, instr_count}, 32'd1);
        exp_q.push_back(16'h1111);
        pulse_step();
        ticks(6);
        chk("step2_count", {16'd0, instr_count}, 32'd2);
        chk("step_q_empty", exp_q.size(), 32'd0);

        // run dropped on the ISSUE cycle: current instruction completes, no more.
        do_reset();
        for (int i = 0; i < 4; i++) load(5'(i), 16'h0100 + 16'(i));
        set_pc(16'd0);
        exp_q.push_back(16'h0100);
        run = 1'b1;
        wait_en2("drop_en2");
        run = 1'b0;
        tick();
        chk("drop_exec_busy", {31'd0, busy}, 32'd1);
        ticks(8);
        chk("drop_busy", {31'd0, busy}, 32'd0);
        chk("drop_count", {16'd0, instr_count}, 32'd1);
        chk("drop_q_empty", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of EXEC.
        do_reset();
        set_pc(16'd0);
        exp_q.push_back(16'h0100);
        run = 1'b1;
        wait_en2("arst_en2");
        tick();
        chk("arst_pre_count", {16'd0, instr_count}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_en_in", {31'd0, bus.en_in}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_count", {16'd0, instr_count}, 32'd0);
        run = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b1;
        tick();

        // pc out of range halts with sticky pc_err.
        do_reset();
        set_pc(16'h0020);
        run = 1'b1;
        wait_halted("pcerr_halted");
        chk("pcerr_flag", {31'd0, pc_err}, 32'd1);
        chk("pcerr_count", {16'd0, instr_count}, 32'd0);
        run = 1'b0;
        ticks(3);
        chk("pcerr_idle", {31'd0, halted}, 32'd0);
        chk("pcerr_busy", {31'd0, busy}, 32'd0);
        chk("pcerr_sticky", {31'd0, pc_err}, 32'd1);

        // Load writes dropped during EXEC, accepted in IDLE.
        do_reset();
        load(5'd0, 16'h0401);
        load(5'd1, 16'h5555);
        set_pc(16'd0);
        exp_q.push_back(16'h0401);
        pulse_step();
        wait_en2("gate_en2");
        tick();
        load(5'd0, 16'h1234);
        ticks(4);
        set_pc(16'd0);
        exp_q.push_back(16'h0401);
        pulse_step();
        ticks(6);
        load(5'd0, 16'h1234);
        set_pc(16'd0);
        exp_q.push_back(16'h1234);
        pulse_step();
        ticks(6);
        chk("gate_count", {16'd0, instr_count}, 32'd3);
        chk("gate_q_empty", exp_q.size(), 32'd0);

        // Random programs against a pc-walking reference model.
        for (int t = 0; t < 15; t++) begin
            do_reset();
            for (int a = 0; a < 32; a++) begin
                model_mem[a] = ($urandom_range(0, 7) == 0) ? HALT : 16'($urandom);
                load(5'(a), model_mem[a]);
            end
            pc = 0;
            n = 0;
            exp_err = 1'b0;
            while (1) begin
                if (pc >= 32) begin
                    exp_err = 1'b1;
                    break;
                end
                w = model_mem[pc];
                if (w == HALT) break;
                exp_q.push_back(w);
                n++;
                pc = w[15] ? pc + 2 + int'(w[1:0]) : pc + 1;
            end
            set_pc(16'd0);
            run = 1'b1;
            wait_halted("rnd_halted");
            chk("rnd_count", {16'd0, instr_count}, n);
            chk("rnd_pc_err", {31'd0, pc_err}, {31'd0, exp_err});
            chk("rnd_en_in", {31'd0, bus.en_in}, 32'd0);
            chk("rnd_q_empty", exp_q.size(), 32'd0);
            run = 1'b0;
            ticks(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
